// File: rtl/cpu6_fetchq.sv
// rtl/cpu6_fetchq.sv - sequential instruction fetch with a DEPTH-entry {pc, instr} queue
// A request is only issued when queue plus in-flight slot has room, so pushes never overflow.
module cpu6_fetchq #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_rvalid,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [XLEN-1:0]          deq_pc,
  output logic [XLEN-1:0]          deq_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_OCC = DEPTH[CW:0];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] instr_mem_d [DEPTH];

  logic            issue;
  logic            push;
  logic            pop;
  logic [CW:0]     occupancy;

  always_comb begin
    occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    issue       = !reset && !redirect && (occupancy < DEPTH_OCC);
    push        = imem_rvalid && inflight_q && !redirect;
    pop         = (count_q != '0) && deq_ready && !redirect;

    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;

    // Redirect wins over everything but reset: flush queue and drop any in-flight word.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
        req_pc_d   = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (push) begin
        pc_mem_d[wr_ptr_q]    = req_pc_q;
        instr_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign deq_valid = (count_q != '0);
  assign deq_pc    = deq_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign deq_instr = deq_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: tb/tb_cpu6_fetchq.sv
// tb/tb_cpu6_fetchq.sv - directed bench for cpu6_fetchq (DEPTH=4 instance and DEPTH=2 wrap instance)
module tb_cpu6_fetchq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect, deq_ready, imem_req, imem_rvalid, deq_valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, deq_pc, deq_instr;
  logic [2:0]  count;
  logic        mem_rvalid, inj_rvalid;
  logic [31:0] mem_rdata, inj_rdata;

  logic        reset2, redirect2, deq_ready2, imem_req2, imem_rvalid2, deq_valid2;
  logic [31:0] redirect_pc2, imem_addr2, imem_rdata2, deq_pc2, deq_instr2;
  logic [1:0]  count2;

  int errors = 0;
  int checks = 0;

  cpu6_fetchq #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_instr(deq_instr), .count(count)
  );

  cpu6_fetchq #(.XLEN(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .deq_valid(deq_valid2), .deq_ready(deq_ready2),
    .deq_pc(deq_pc2), .deq_instr(deq_instr2), .count(count2)
  );

  // Memory answers one cycle after each request with addr ^ 0xA5A5.
  always @(posedge clk) begin
    mem_rvalid   <= imem_req;
    mem_rdata    <= imem_addr ^ 32'hA5A5;
    imem_rvalid2 <= imem_req2;
    imem_rdata2  <= imem_addr2 ^ 32'hA5A5;
  end
  assign imem_rvalid = mem_rvalid | inj_rvalid;
  assign imem_rdata  = inj_rvalid ? inj_rdata : mem_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  logic [31:0] exp_pc2, exp_addr2;
  int          pops2;

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; deq_ready = 1'b1;
    inj_rvalid = 1'b0; inj_rdata = '0; mem_rvalid = 1'b0; mem_rdata = '0;
    reset2 = 1'b1; redirect2 = 1'b0; redirect_pc2 = '0; deq_ready2 = 1'b0;
    imem_rvalid2 = 1'b0; imem_rdata2 = '0;
    nxt; nxt; #1;
    chk("rst_count", count, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_deq_pc", deq_pc, 0);
    chk("rst_deq_instr", deq_instr, 0);
    chk("rst2_count", count2, 0);
    chk("rst2_imem_req", imem_req2, 0);

    // Streaming from reset: cycle 0 is the cycle in which reset is released.
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k != 0) nxt;
      #1;
      chk("t1_req", imem_req, 1);
      chk("t1_addr", imem_addr, 32'(4 * k));
      if (k >= 2) begin
        chk("t1_valid", deq_valid, 1);
        chk("t1_pc", deq_pc, 32'(4 * (k - 2)));
        chk("t1_instr", deq_instr, 32'(4 * (k - 2)) ^ 32'hA5A5);
        chk("t1_count", count, 1);
      end else begin
        chk("t1_valid_early", deq_valid, 0);
      end
    end

    // Decode stall: queue fills to 4, fetch stops, head stays put.
    for (int j = 0; j < 10; j++) begin
      nxt; deq_ready = 1'b0; #1;
      chk("t2_valid", deq_valid, 1);
      chk("t2_pc_hold", deq_pc, 32'd32);
      chk("t2_count", count, (j < 3) ? j + 1 : 4);
      chk("t2_req", imem_req, (j < 2) ? 1 : 0);
      if (j < 2) chk("t2_addr", imem_addr, 32'(40 + 4 * j));
    end
    for (int m = 0; m < 10; m++) begin
      nxt; deq_ready = 1'b1; #1;
      chk("t2_drain_valid", deq_valid, 1);
      chk("t2_drain_pc", deq_pc, 32'(32 + 4 * m));
      chk("t2_drain_instr", deq_instr, 32'(32 + 4 * m) ^ 32'hA5A5);
      chk("t2_drain_req", imem_req, (m != 0) ? 1 : 0);
      if (m != 0) chk("t2_drain_addr", imem_addr, 32'(48 + 4 * (m - 1)));
    end

    // Build 3 entries plus one in flight, then redirect to 0x100.
    nxt; deq_ready = 1'b0; #1;
    chk("t3_pre_count", count, 2);
    chk("t3_pre_addr", imem_addr, 32'd84);
    nxt; deq_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h100; #1;
    chk("t3_count3", count, 3);
    chk("t3_head", deq_pc, 32'd72);
    chk("t3_no_req", imem_req, 0);
    nxt; redirect = 1'b0; #1;
    chk("t3_flush_count", count, 0);
    chk("t3_flush_valid", deq_valid, 0);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);
    nxt; #1;
    chk("t3_drop_valid", deq_valid, 0);
    chk("t3_addr2", imem_addr, 32'h104);
    nxt; #1;
    chk("t3_first_valid", deq_valid, 1);
    chk("t3_first_pc", deq_pc, 32'h100);
    chk("t3_first_instr", deq_instr, 32'h100 ^ 32'hA5A5);
    nxt; #1;
    chk("t3_second_pc", deq_pc, 32'h104);

    // Redirect together with deq_ready and a returning word.
    nxt; redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk("t4_rvalid_present", imem_rvalid & deq_valid, 1);
    chk("t4_head", deq_pc, 32'h108);
    chk("t4_no_req", imem_req, 0);
    nxt; redirect = 1'b0; #1;
    chk("t4_count", count, 0);
    chk("t4_valid", deq_valid, 0);
    chk("t4_addr", imem_addr, 32'h200);
    nxt; #1;
    chk("t4_valid2", deq_valid, 0);
    nxt; #1;
    chk("t4_pc", deq_pc, 32'h200);

    // Reset mid-stream, then a stale response after reset.
    nxt; reset = 1'b1; #1;
    chk("t5_req_in_reset", imem_req, 0);
    nxt; reset = 1'b0; inj_rvalid = 1'b1; inj_rdata = 32'hDEAD_BEEF; #1;
    chk("t5_count", count, 0);
    chk("t5_valid", deq_valid, 0);
    chk("t5_deq_pc", deq_pc, 0);
    chk("t5_deq_instr", deq_instr, 0);
    chk("t5_req", imem_req, 1);
    chk("t5_addr", imem_addr, 0);
    nxt; inj_rvalid = 1'b0; #1;
    chk("t5_stale_dropped", count, 0);
    chk("t5_addr2", imem_addr, 32'h4);
    nxt; #1;
    chk("t5_valid_after", deq_valid, 1);
    chk("t5_pc_after", deq_pc, 32'h0);
    chk("t5_instr_after", deq_instr, 32'hA5A5);

    // DEPTH=2 with random decode stalls across the address wrap.
    exp_pc2 = 32'hFFFF_FFF8;
    exp_addr2 = 32'hFFFF_FFF8;
    pops2 = 0;
    nxt; reset2 = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (i != 0) nxt;
      deq_ready2 = 1'($urandom_range(0, 1));
      #1;
      if (i == 0) chk("t6_first_req", imem_req2, 1);
      chk("t6_count_le2", (count2 <= 2'd2) ? 1 : 0, 1);
      if (imem_req2) begin
        chk("t6_addr", imem_addr2, exp_addr2);
        exp_addr2 = exp_addr2 + 32'd4;
      end
      if (deq_valid2 && deq_ready2) begin
        chk("t6_pc", deq_pc2, exp_pc2);
        chk("t6_instr", deq_instr2, exp_pc2 ^ 32'hA5A5);
        exp_pc2 = exp_pc2 + 32'd4;
        pops2++;
      end
    end
    chk("t6_wrapped", (pops2 >= 4) ? 1 : 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
